// File: rtl/game_pkg.sv
// Shared game constants: line positions, player size, controller states and contact helper.
package game_pkg;

  localparam int LINE_Y0  = 120;
  localparam int LINE_Y1  = 240;
  localparam int LINE_Y2  = 360;
  localparam int PLAYER_H = 60;

  // Height at which the player's feet touch a line when falling down.
  localparam int STAND_Y1 = LINE_Y1 - PLAYER_H;
  localparam int STAND_Y2 = LINE_Y2 - PLAYER_H;

  typedef enum logic [1:0] {GND, AIR, DEAD} state_t;

  // Falling down the player rests on top of a line; falling up its head hits the line.
  function automatic logic on_ground(input logic grav, input logic [8:0] h,
                                     input logic [2:0] lines);
    if (grav)
      return ((h == 9'(LINE_Y0)) && lines[0]) || ((h == 9'(LINE_Y1)) && lines[1]);
    else
      return ((h == 9'(STAND_Y1)) && lines[1]) || ((h == 9'(STAND_Y2)) && lines[2]);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus down-counter debouncer; emits the committed level and a rise pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEB_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= RELOAD;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any sample that agrees with the committed level restarts the stability window.
      if (sync2 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= RELOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/gravity_ctrl.sv
// Player gravity controller: flip acceptance, landing/death detection, flip counter.
// Optional FLIP_BUFFER_EN macro buffers one flip pressed mid-air until the next landing.
//
//  state | meaning
//  GND   | standing on a line, flips accepted
//  AIR   | moving between lines
//  DEAD  | left the screen, frozen until restart
module gravity_ctrl
  import game_pkg::*;
#(
  parameter int DEB_CYCLES  = 250000,
  parameter int H_BOT_DEATH = 420,
  parameter int H_TOP_DEATH = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flip_btn,
  input  logic             restart,
  input  logic [8:0]       height,
  input  logic [2:0]       lines,
  output logic             grav_dir,
  output logic             is_dead,
  output logic             grounded,
  output logic [CNT_W-1:0] flip_count
);

  state_t           state, state_nxt;
  logic             grav_nxt;
  logic [CNT_W-1:0] cnt_nxt, cnt_inc;
  logic             flip_req, btn_level, death, take_buf;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .btn   (flip_btn),
    .level (btn_level),
    .rise  (flip_req)
  );

  assign grounded = on_ground(grav_dir, height, lines);
  assign death    = grav_dir ? (32'(height) <= 32'(H_TOP_DEATH))
                             : (32'(height) >= 32'(H_BOT_DEATH));
  assign cnt_inc  = (flip_count == '1) ? flip_count : flip_count + 1'b1;

`ifdef FLIP_BUFFER_EN
  logic pending;

  // A request arriving on the landing cycle itself is honoured the same as a buffered one.
  assign take_buf = pending | flip_req;

  always_ff @(posedge clk) begin
    if (rst || restart)
      pending <= 1'b0;
    else if (state == AIR)
      pending <= (death || grounded) ? 1'b0 : (pending | flip_req);
  end
`else
  assign take_buf = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grav_nxt  = grav_dir;
    cnt_nxt   = flip_count;
    if (restart) begin
      state_nxt = AIR;
      grav_nxt  = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        AIR: begin
          if (death) begin
            state_nxt = DEAD;
          end else if (grounded) begin
            if (take_buf) begin
              grav_nxt = ~grav_dir;
              cnt_nxt  = cnt_inc;
            end else begin
              state_nxt = GND;
            end
          end
        end
        GND: begin
          if (death) begin
            state_nxt = DEAD;
          end else if (flip_req) begin
            grav_nxt  = ~grav_dir;
            cnt_nxt   = cnt_inc;
            state_nxt = AIR;
          end else if (!grounded) begin
            state_nxt = AIR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= AIR;
      grav_dir   <= 1'b0;
      flip_count <= '0;
      is_dead    <= 1'b0;
    end else begin
      state      <= state_nxt;
      grav_dir   <= grav_nxt;
      flip_count <= cnt_nxt;
      is_dead    <= (state_nxt == DEAD);
    end
  end

endmodule

// File: tb/tb_gravity_ctrl.sv
// Randomized and directed bench for gravity_ctrl against a cycle-level behavioural model.
module tb_gravity_ctrl;
  import game_pkg::*;

  localparam int DEB = 4;
`ifdef FLIP_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  localparam int M_GND = 0, M_AIR = 1, M_DEAD = 2;

  logic       clk = 1'b0;
  logic       rst, flip_btn, restart;
  logic [8:0] height;
  logic [2:0] lines;
  logic       grav_dir, is_dead, grounded;
  logic [7:0] flip_count;

  int n_chk = 0, n_fail = 0;

  // reference model state
  int m_s1, m_s2, m_lvl, m_run, m_req;
  int m_st, m_grav, m_cnt, m_pend;

  always #5 clk = ~clk;

  gravity_ctrl #(.DEB_CYCLES(DEB), .H_BOT_DEATH(420), .H_TOP_DEATH(0), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flip_btn   (flip_btn),
    .restart    (restart),
    .height     (height),
    .lines      (lines),
    .grav_dir   (grav_dir),
    .is_dead    (is_dead),
    .grounded   (grounded),
    .flip_count (flip_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_grounded();
    int h = int'(height);
    if (m_grav != 0) return ((h == 120 && lines[0]) || (h == 240 && lines[1])) ? 1 : 0;
    return ((h == 180 && lines[1]) || (h == 300 && lines[2])) ? 1 : 0;
  endfunction

  function automatic int m_death();
    int h = int'(height);
    if (m_grav != 0) return (h <= 0) ? 1 : 0;
    return (h >= 420) ? 1 : 0;
  endfunction

  // One clock: check combinational contact, advance model and DUT, check registered outputs.
  task automatic step();
    int g, d, fr;
    int n_s1, n_s2, n_lvl, n_run, n_req, n_st, n_grav, n_cnt, n_pend;
    #1;
    g = m_grounded();
    chk("grounded", int'(grounded), g);
    if (rst) begin
      n_s1 = 0; n_s2 = 0; n_lvl = 0; n_run = 0; n_req = 0;
      n_st = M_AIR; n_grav = 0; n_cnt = 0; n_pend = 0;
    end else begin
      fr = m_req;
      n_s1 = int'(flip_btn); n_s2 = m_s1;
      n_lvl = m_lvl; n_req = 0; n_run = 0;
      if (m_s2 != m_lvl) begin
        if (m_run + 1 == DEB) begin
          n_lvl = m_s2; n_req = m_s2;
        end else begin
          n_run = m_run + 1;
        end
      end
      d = m_death();
      n_st = m_st; n_grav = m_grav; n_cnt = m_cnt; n_pend = m_pend;
      if (restart) begin
        n_st = M_AIR; n_grav = 0; n_cnt = 0; n_pend = 0;
      end else if (m_st == M_AIR) begin
        if (d != 0) begin
          n_st = M_DEAD; n_pend = 0;
        end else if (g != 0) begin
          if (BUF && (m_pend != 0 || fr != 0)) begin
            n_grav = 1 - m_grav; n_cnt = (m_cnt == 255) ? 255 : m_cnt + 1; n_pend = 0;
          end else begin
            n_st = M_GND;
          end
        end else if (BUF && fr != 0) begin
          n_pend = 1;
        end
      end else if (m_st == M_GND) begin
        if (d != 0) n_st = M_DEAD;
        else if (fr != 0) begin
          n_grav = 1 - m_grav; n_cnt = (m_cnt == 255) ? 255 : m_cnt + 1; n_st = M_AIR;
        end else if (g == 0) n_st = M_AIR;
      end
    end
    @(posedge clk);
    m_s1 = n_s1; m_s2 = n_s2; m_lvl = n_lvl; m_run = n_run; m_req = n_req;
    m_st = n_st; m_grav = n_grav; m_cnt = n_cnt; m_pend = n_pend;
    #1;
    chk("grav_dir", int'(grav_dir), m_grav);
    chk("is_dead", int'(is_dead), (m_st == M_DEAD) ? 1 : 0);
    chk("flip_count", int'(flip_count), m_cnt);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_restart();
    restart = 1'b1; step(); restart = 1'b0;
  endtask

  initial begin
    int heights[12] = '{0, 60, 120, 180, 240, 300, 360, 400, 419, 420, 450, 1};
    int hold;
    rst = 1'b1; flip_btn = 1'b0; restart = 1'b0; height = 9'd300; lines = 3'b111;
    repeat (2) @(posedge clk);
    step();
    chk("t1_reset_grav", int'(grav_dir), 0);
    chk("t1_reset_dead", int'(is_dead), 0);
    rst = 1'b0;
    step();
    chk("t1_state_gnd", int'(dut.state == GND), 1);

    // clean press from GND: flip lands exactly 7 clocks after the press
    flip_btn = 1'b1;
    steps(6);
    chk("t2_before", int'(grav_dir), 0);
    step();
    chk("t2_flipped", int'(grav_dir), 1);
    chk("t2_count", int'(flip_count), 1);
    flip_btn = 1'b0; steps(8);
    flip_btn = 1'b1; steps(8);
    flip_btn = 1'b0; steps(8);
    chk("t2_air_press", int'(flip_count), 1);

    // chatter never reaches a stable window
    for (int i = 0; i < 10; i++) begin
      flip_btn = 1'b1; step();
      flip_btn = 1'b0; step();
    end
    steps(8);
    chk("t3_chatter", int'(grav_dir), 1);

    // fall off the bottom
    pulse_restart();
    lines = 3'b000;
    for (int h = 400; h <= 420; h++) begin
      height = 9'(h);
      step();
      if (h == 419) chk("t4_alive_419", int'(is_dead), 0);
    end
    chk("t4_dead_420", int'(is_dead), 1);
    flip_btn = 1'b1; steps(8);
    chk("t4_dead_press", int'(grav_dir), 0);
    flip_btn = 1'b0; steps(8);
    pulse_restart();
    chk("t4_restart_dead", int'(is_dead), 0);
    chk("t4_restart_cnt", int'(flip_count), 0);

    // death and flip_req on the same cycle
    height = 9'd300; lines = 3'b111;
    steps(2);
    flip_btn = 1'b1; steps(6);
    height = 9'd420; step();
    chk("t5_dead", int'(is_dead), 1);
    chk("t5_no_flip", int'(grav_dir), 0);
    flip_btn = 1'b0; steps(8);

    // mid-air press then landing at the top line
    pulse_restart();
    height = 9'd300; steps(2);
    flip_btn = 1'b1; steps(7);
    flip_btn = 1'b0; steps(8);
    lines = 3'b001; height = 9'd200; steps(2);
    flip_btn = 1'b1; steps(8);
    flip_btn = 1'b0; steps(8);
    height = 9'd120; step();
`ifdef FLIP_BUFFER_EN
    chk("t6_buffered_flip", int'(grav_dir), 0);
    chk("t6_state_air", int'(dut.state == AIR), 1);
    chk("t6_count", int'(flip_count), 2);
`else
    chk("t6_no_buffer", int'(grav_dir), 1);
    chk("t6_state_gnd", int'(dut.state == GND), 1);
    chk("t6_count", int'(flip_count), 1);
`endif

    // counter saturation
    pulse_restart();
    lines = 3'b111;
    for (int i = 0; i < 258; i++) begin
      height = (m_grav != 0) ? 9'd240 : 9'd300;
      flip_btn = 1'b1; steps(8);
      flip_btn = 1'b0; steps(7);
    end
    chk("sat_255", int'(flip_count), 255);

    // random soak
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        flip_btn = ~flip_btn;
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
      end
      hold--;
      if ($urandom_range(0, 1) == 0) begin
        height = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511))
                                             : 9'(heights[$urandom_range(0, 11)]);
      end
      if ($urandom_range(0, 7) == 0) lines = 3'($urandom_range(0, 7));
      restart = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0; restart = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
